// File: rtl/stopwatch_controller_if.sv
// rtl/stopwatch_controller_if.sv - button, time and display signal bundle for the stopwatch controller
// Purpose: groups every non-clock/reset signal of stopwatch_controller.
// Ports (as seen by the controller, slave modport):
//   in  btn_start_stop, btn_lap_reset  debounced button levels
//   in  minutes[6:0], seconds[6:0]     live time from the time counter
//   out counter_reset, hold_count      time counter controls
//   out disp_minutes[6:0], disp_seconds[6:0], lap_active, overflow, state_dbg[2:0]
interface stopwatch_controller_if;
    logic       btn_start_stop;
    logic       btn_lap_reset;
    logic [6:0] minutes;
    logic [6:0] seconds;
    logic       counter_reset;
    logic       hold_count;
    logic [6:0] disp_minutes;
    logic [6:0] disp_seconds;
    logic       lap_active;
    logic       overflow;
    logic [2:0] state_dbg;

    modport master (
        output btn_start_stop, btn_lap_reset, minutes, seconds,
        input  counter_reset, hold_count, disp_minutes, disp_seconds,
               lap_active, overflow, state_dbg
    );

    modport slave (
        input  btn_start_stop, btn_lap_reset, minutes, seconds,
        output counter_reset, hold_count, disp_minutes, disp_seconds,
               lap_active, overflow, state_dbg
    );
endinterface

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - stopwatch control FSM with lap freeze, stretched clear and overflow stop
// Purpose: converts two debounced button levels into hold/clear controls for the time
//   counter and selects live or lapped time for the display.
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  synchronous, active-high
//   sw     stopwatch_controller_if.slave (buttons, live time, controls, display, status)
module stopwatch_controller #(
    parameter int CLR_CYCLES  = 4,
    parameter int MAX_MINUTES = 99
) (
    input  logic                   clock,
    input  logic                   reset,
    stopwatch_controller_if.slave  sw
);

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RUNNING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_LAP     = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic          btn_ss_q, btn_lr_q;
    logic [6:0]    lap_min_q, lap_min_d;
    logic [6:0]    lap_sec_q, lap_sec_d;
    logic [6:0]    disp_min_q, disp_min_d;
    logic [6:0]    disp_sec_q, disp_sec_d;
    logic          overflow_q, overflow_d;

    logic ss_press;
    logic lr_press;
    logic at_max;

    // Start/stop wins a same-cycle collision, so the lap press is masked off.
    assign ss_press = sw.btn_start_stop & ~btn_ss_q;
    assign lr_press = sw.btn_lap_reset & ~btn_lr_q & ~ss_press;
    assign at_max   = (sw.minutes == 7'(MAX_MINUTES)) && (sw.seconds == 7'd59);

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            // Loading 1 means a button held through reset is not seen as a press.
            btn_ss_q   <= 1'b1;
            btn_lr_q   <= 1'b1;
            lap_min_q  <= '0;
            lap_sec_q  <= '0;
            disp_min_q <= '0;
            disp_sec_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            btn_ss_q   <= sw.btn_start_stop;
            btn_lr_q   <= sw.btn_lap_reset;
            lap_min_q  <= lap_min_d;
            lap_sec_q  <= lap_sec_d;
            disp_min_q <= disp_min_d;
            disp_sec_q <= disp_sec_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = '0;
        lap_min_d  = lap_min_q;
        lap_sec_d  = lap_sec_q;
        overflow_d = overflow_q;

        unique case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == CW'(CLR_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (ss_press)      state_d = ST_RUNNING;
                else if (lr_press) state_d = ST_CLEAR;
            end
            ST_RUNNING: begin
                if (at_max) begin
                    state_d    = ST_PAUSED;
                    overflow_d = 1'b1;
                end else if (ss_press) begin
                    state_d = ST_PAUSED;
                end else if (lr_press) begin
                    state_d   = ST_LAP;
                    lap_min_d = sw.minutes;
                    lap_sec_d = sw.seconds;
                end
            end
            ST_LAP: begin
                if (at_max) begin
                    state_d    = ST_PAUSED;
                    overflow_d = 1'b1;
                end else if (ss_press) begin
                    state_d = ST_PAUSED;
                end else if (lr_press) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_PAUSED: begin
                // After an overflow only a clear may leave PAUSED.
                if (ss_press && !overflow_q) state_d = ST_RUNNING;
                else if (lr_press)           state_d = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase

        if (state_d == ST_CLEAR && state_q != ST_CLEAR) begin
            overflow_d = 1'b0;
        end

        // Display source follows the state being entered so it switches on the
        // same edge as lap_active.
        if (state_d == ST_CLEAR) begin
            disp_min_d = '0;
            disp_sec_d = '0;
        end else if (state_d == ST_LAP) begin
            disp_min_d = lap_min_d;
            disp_sec_d = lap_sec_d;
        end else begin
            disp_min_d = sw.minutes;
            disp_sec_d = sw.seconds;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        sw.counter_reset = (state_q == ST_CLEAR);
        sw.hold_count    = (state_q == ST_CLEAR) || (state_q == ST_IDLE) ||
                           (state_q == ST_PAUSED);
        sw.lap_active    = (state_q == ST_LAP);
        sw.disp_minutes  = disp_min_q;
        sw.disp_seconds  = disp_sec_q;
        sw.overflow      = overflow_q;
        sw.state_dbg     = state_q;
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - vector table and scoreboard bench for stopwatch_controller
module tb_stopwatch_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    stopwatch_controller_if sw ();

    stopwatch_controller #(
        .CLR_CYCLES  (4),
        .MAX_MINUTES (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sw    (sw.slave)
    );

    typedef struct {
        logic       ss;
        logic       lr;
        logic [6:0] m;
        logic [6:0] s;
        logic       cr;
        logic       hold;
        logic       lap;
        logic       ovf;
        logic [2:0] st;
        logic [6:0] dm;
        logic [6:0] ds;
    } vec_t;

    vec_t exp_q[$];
    vec_t t_main[$];
    vec_t t_held[$];
    vec_t t_ovf[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic ss, input logic lr, input int m, input int s,
                                input logic cr, input logic hold, input logic lap,
                                input logic ovf, input int st, input int dm, input int ds);
        vec_t v;
        v.ss = ss; v.lr = lr; v.m = 7'(m); v.s = 7'(s);
        v.cr = cr; v.hold = hold; v.lap = lap; v.ovf = ovf;
        v.st = 3'(st); v.dm = 7'(dm); v.ds = 7'(ds);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        chk({tag, ".counter_reset"}, int'(sw.counter_reset), int'(e.cr));
        chk({tag, ".hold_count"},    int'(sw.hold_count),    int'(e.hold));
        chk({tag, ".lap_active"},    int'(sw.lap_active),    int'(e.lap));
        chk({tag, ".overflow"},      int'(sw.overflow),      int'(e.ovf));
        chk({tag, ".state_dbg"},     int'(sw.state_dbg),     int'(e.st));
        chk({tag, ".disp_minutes"},  int'(sw.disp_minutes),  int'(e.dm));
        chk({tag, ".disp_seconds"},  int'(sw.disp_seconds),  int'(e.ds));
    endtask

    // Drive at the falling edge, push the expectation, sample one falling edge later.
    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        sw.btn_start_stop = v.ss;
        sw.btn_lap_reset  = v.lr;
        sw.minutes        = v.m;
        sw.seconds        = v.s;
        exp_q.push_back(v);
        @(posedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        check_outputs(tag, e);
    endtask

    task automatic check_reset_state(input string tag);
        check_outputs(tag, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    endtask

    initial begin
        // Post-reset run: clear stretch, start/pause, lap, clear from pause, collision.
        //                ss lr  m   s   cr h  lap ov st dm ds
        t_main.push_back(mk(0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0));
        t_main.push_back(mk(0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0));
        t_main.push_back(mk(0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0));
        t_main.push_back(mk(0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0));
        t_main.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0, 2, 0, 0));
        t_main.push_back(mk(0, 0, 0, 1,   0, 0, 0, 0, 2, 0, 1));
        t_main.push_back(mk(1, 0, 0, 2,   0, 1, 0, 0, 3, 0, 2));
        t_main.push_back(mk(0, 0, 0, 2,   0, 1, 0, 0, 3, 0, 2));
        t_main.push_back(mk(1, 0, 0, 11,  0, 0, 0, 0, 2, 0, 11));
        t_main.push_back(mk(0, 0, 0, 12,  0, 0, 0, 0, 2, 0, 12));
        t_main.push_back(mk(0, 1, 0, 12,  0, 0, 1, 0, 4, 0, 12));
        t_main.push_back(mk(0, 1, 0, 13,  0, 0, 1, 0, 4, 0, 12));
        t_main.push_back(mk(0, 0, 0, 14,  0, 0, 1, 0, 4, 0, 12));
        t_main.push_back(mk(0, 1, 0, 15,  0, 0, 0, 0, 2, 0, 15));
        t_main.push_back(mk(0, 0, 0, 16,  0, 0, 0, 0, 2, 0, 16));
        t_main.push_back(mk(0, 1, 0, 17,  0, 0, 1, 0, 4, 0, 17));
        t_main.push_back(mk(0, 0, 0, 18,  0, 0, 1, 0, 4, 0, 17));
        t_main.push_back(mk(1, 0, 0, 18,  0, 1, 0, 0, 3, 0, 18));
        t_main.push_back(mk(0, 0, 0, 18,  0, 1, 0, 0, 3, 0, 18));
        t_main.push_back(mk(0, 1, 0, 18,  1, 1, 0, 0, 0, 0, 0));
        t_main.push_back(mk(0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0));
        t_main.push_back(mk(1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0));
        t_main.push_back(mk(0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0));
        t_main.push_back(mk(0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0));
        t_main.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0, 2, 0, 0));
        t_main.push_back(mk(0, 0, 0, 20,  0, 0, 0, 0, 2, 0, 20));
        t_main.push_back(mk(1, 1, 0, 21,  0, 1, 0, 0, 3, 0, 21));
        t_main.push_back(mk(1, 1, 0, 21,  0, 1, 0, 0, 3, 0, 21));

        // After a reset with start_stop held high: clear stretch then IDLE, no start.
        t_held.push_back(mk(1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0));
        t_held.push_back(mk(1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0));
        t_held.push_back(mk(1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0));
        t_held.push_back(mk(1, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0));
        t_held.push_back(mk(1, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0));
        t_held.push_back(mk(0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0));

        // Overflow at 01:59 (MAX_MINUTES=1), from RUNNING then from LAP over a lap press.
        t_ovf.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0, 2, 0, 0));
        t_ovf.push_back(mk(0, 0, 1, 58,   0, 0, 0, 0, 2, 1, 58));
        t_ovf.push_back(mk(0, 0, 1, 59,   0, 1, 0, 1, 3, 1, 59));
        t_ovf.push_back(mk(1, 0, 1, 59,   0, 1, 0, 1, 3, 1, 59));
        t_ovf.push_back(mk(0, 0, 1, 59,   0, 1, 0, 1, 3, 1, 59));
        t_ovf.push_back(mk(0, 1, 1, 59,   1, 1, 0, 0, 0, 0, 0));
        t_ovf.push_back(mk(0, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0));
        t_ovf.push_back(mk(0, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0));
        t_ovf.push_back(mk(0, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0));
        t_ovf.push_back(mk(0, 0, 0, 0,    0, 1, 0, 0, 1, 0, 0));
        t_ovf.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0, 2, 0, 0));
        t_ovf.push_back(mk(0, 1, 1, 0,    0, 0, 1, 0, 4, 1, 0));
        t_ovf.push_back(mk(0, 0, 1, 58,   0, 0, 1, 0, 4, 1, 0));
        t_ovf.push_back(mk(0, 1, 1, 59,   0, 1, 0, 1, 3, 1, 59));

        sw.btn_start_stop = 1'b0;
        sw.btn_lap_reset  = 1'b0;
        sw.minutes        = '0;
        sw.seconds        = '0;

        // Reset for three clocks, then release at a falling edge.
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_state("reset");
        reset = 1'b0;
        for (int i = 0; i < t_main.size(); i++) apply($sformatf("main[%0d]", i), t_main[i]);

        // Reset from PAUSED with start_stop held high through and after reset.
        sw.btn_start_stop = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_state("held_reset");
        reset = 1'b0;
        for (int i = 0; i < t_held.size(); i++) apply($sformatf("held[%0d]", i), t_held[i]);

        for (int i = 0; i < t_ovf.size(); i++) apply($sformatf("ovf[%0d]", i), t_ovf[i]);

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
